data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the pipelined CPU's MEM-stage port (`read_m2`/`write_m2`/`address2`/`data2`) and the multi-cycle backing data memory. Read hits return data combinationally in the request cycle. Read misses fetch a whole line over a wide req/ack memory port and then hit. Every write goes to memory and updates the line only if it is present; the CPU freezes its pipeline while `cpu_ready` is low.

---
 rtl/data_cache_pkg.sv | 18 +
 rtl/dcache_line_store.sv | 52 +++++
 rtl/data_cache.sv | 162 ++++++++++++++++
 tb/tb_data_cache.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared definitions for the data cache: word size, default geometry and FSM state encodings.
package data_cache_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int DC_INDEX_BITS  = 2;
    localparam int DC_OFFSET_BITS = 2;

    function automatic int dc_tag_bits(input int index_bits, input int offset_bits);
        return WORD_SIZE - index_bits - offset_bits;
    endfunction

    typedef enum logic [1:0] {
        DC_IDLE  = 2'd0,
        DC_FILL  = 2'd1,
        DC_WRITE = 2'd2
    } dc_state_t;

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays of the direct-mapped data cache: combinational read by index,
// synchronous whole-line fill or single-word write, asynchronous clear of the valid bits.
module dcache_line_store
    import data_cache_pkg::*;
#(
    parameter int INDEX_BITS  = DC_INDEX_BITS,
    parameter int OFFSET_BITS = DC_OFFSET_BITS,
    parameter int TAG_BITS    = dc_tag_bits(DC_INDEX_BITS, DC_OFFSET_BITS)
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [INDEX_BITS-1:0]                    i_index,
    output logic                                     o_valid,
    output logic [TAG_BITS-1:0]                      o_tag,
    output logic [WORD_SIZE*(2**OFFSET_BITS)-1:0]    o_line,
    input  logic                                     i_fill_en,
    input  logic [TAG_BITS-1:0]                      i_fill_tag,
    input  logic [WORD_SIZE*(2**OFFSET_BITS)-1:0]    i_fill_line,
    input  logic                                     i_wr_en,
    input  logic [OFFSET_BITS-1:0]                   i_wr_offset,
    input  logic [WORD_SIZE-1:0]                     i_wr_data
);
    localparam int LINES  = 2**INDEX_BITS;
    localparam int LINE_W = WORD_SIZE * (2**OFFSET_BITS);

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [LINE_W-1:0]   r_data [LINES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[i_index] <= 1'b1;
        end
    end

    // Tags and data are deliberately left unreset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_index]  <= i_fill_tag;
            r_data[i_index] <= i_fill_line;
        end else if (i_wr_en) begin
            r_data[i_index][i_wr_offset*WORD_SIZE +: WORD_SIZE] <= i_wr_data;
        end
    end

    assign o_valid = r_valid[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_line  = r_data[i_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with line fill over a wide memory port.
// Optional hit/miss statistics counters are built only when DCACHE_STATS_EN is defined.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int INDEX_BITS  = DC_INDEX_BITS,
    parameter int OFFSET_BITS = DC_OFFSET_BITS
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     cpu_read,
    input  logic                                     cpu_write,
    input  logic [WORD_SIZE-1:0]                     cpu_addr,
    input  logic [WORD_SIZE-1:0]                     cpu_wdata,
    output logic [WORD_SIZE-1:0]                     cpu_rdata,
    output logic                                     cpu_ready,
    output logic                                     mem_req,
    output logic                                     mem_we,
    output logic [WORD_SIZE-1:0]                     mem_addr,
    output logic [WORD_SIZE-1:0]                     mem_wdata,
    input  logic [WORD_SIZE*(2**OFFSET_BITS)-1:0]    mem_rdata,
    input  logic                                     mem_ack,
    output logic [WORD_SIZE-1:0]                     hit_count,
    output logic [WORD_SIZE-1:0]                     miss_count
);
    localparam int TAG_BITS = dc_tag_bits(INDEX_BITS, OFFSET_BITS);
    localparam int LINE_W   = WORD_SIZE * (2**OFFSET_BITS);

    dc_state_t              r_state;
    logic                   r_mem_req;
    logic                   r_mem_we;
    logic [WORD_SIZE-1:0]   r_mem_addr;
    logic [WORD_SIZE-1:0]   r_mem_wdata;

    logic [TAG_BITS-1:0]    w_tag;
    logic [INDEX_BITS-1:0]  w_index;
    logic [OFFSET_BITS-1:0] w_offset;
    logic                   w_line_valid;
    logic [TAG_BITS-1:0]    w_line_tag;
    logic [LINE_W-1:0]      w_line;
    logic                   w_hit;
    logic                   w_rd_only;
    logic                   w_rd_hit;
    logic                   w_miss_start;
    logic                   w_fill_en;
    logic                   w_wr_en;
    logic [WORD_SIZE-1:0]   w_line_addr;

    assign w_tag       = cpu_addr[WORD_SIZE-1 -: TAG_BITS];
    assign w_index     = cpu_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_offset    = cpu_addr[OFFSET_BITS-1:0];
    assign w_line_addr = {cpu_addr[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    dcache_line_store #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_BITS    (TAG_BITS)
    ) u_store (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_index     (w_index),
        .o_valid     (w_line_valid),
        .o_tag       (w_line_tag),
        .o_line      (w_line),
        .i_fill_en   (w_fill_en),
        .i_fill_tag  (w_tag),
        .i_fill_line (mem_rdata),
        .i_wr_en     (w_wr_en),
        .i_wr_offset (w_offset),
        .i_wr_data   (cpu_wdata)
    );

    // A simultaneous read and write is treated as a write.
    assign w_hit        = w_line_valid && (w_line_tag == w_tag);
    assign w_rd_only    = cpu_read && !cpu_write;
    assign w_rd_hit     = (r_state == DC_IDLE) && w_rd_only && w_hit;
    assign w_miss_start = (r_state == DC_IDLE) && w_rd_only && !w_hit;
    assign w_fill_en    = (r_state == DC_FILL) && mem_ack;
    assign w_wr_en      = (r_state == DC_WRITE) && mem_ack && w_hit;

    assign cpu_ready = w_rd_hit || ((r_state == DC_WRITE) && mem_ack);
    assign cpu_rdata = w_rd_hit ? w_line[w_offset*WORD_SIZE +: WORD_SIZE] : '0;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= DC_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                DC_IDLE: begin
                    if (cpu_write) begin
                        r_state     <= DC_WRITE;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= cpu_addr;
                        r_mem_wdata <= cpu_wdata;
                    end else if (w_miss_start) begin
                        r_state     <= DC_FILL;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= w_line_addr;
                        r_mem_wdata <= '0;
                    end
                end
                DC_FILL, DC_WRITE: begin
                    if (mem_ack) begin
                        r_state     <= DC_IDLE;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                    end
                end
                default: begin
                    r_state     <= DC_IDLE;
                    r_mem_req   <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic                 r_retry;
    logic [WORD_SIZE-1:0] r_hit_count;
    logic [WORD_SIZE-1:0] r_miss_count;

    // r_retry marks the IDLE cycle right after a fill so its hit is not counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retry      <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_retry <= w_fill_en;
            if (w_rd_hit && !r_retry && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            if (w_miss_start && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: transaction-level reference model plus a per-cycle compare process.
module tb_data_cache;
    import data_cache_pkg::*;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_read, cpu_write;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_count, miss_count;

    always #5 clk = ~clk;

    data_cache dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: backing memory plus which line (tag) each index currently holds.
    logic [15:0] mem_m [0:65535];
    bit          m_valid [4];
    logic [11:0] m_tag   [4];

    logic        exp_ready, exp_req, exp_we;
    logic [15:0] exp_rdata, exp_addr, exp_wdata;
    bit          exp_chk_rdata, exp_chk_wdata;
    int          exp_hits, exp_miss;

    logic [15:0] last_rdata, last_mem_addr;
    int          last_ready_cyc, req_cyc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic bit m_hit(input logic [15:0] a);
        return m_valid[a[3:2]] && (m_tag[a[3:2]] == a[15:4]);
    endfunction

    function automatic logic [63:0] line_of(input logic [15:0] a);
        logic [15:0] b;
        b = {a[15:2], 2'b00};
        return {mem_m[b + 16'd3], mem_m[b + 16'd2], mem_m[b + 16'd1], mem_m[b]};
    endfunction

    task automatic idle_exp();
        exp_ready     = 1'b0;
        exp_rdata     = '0;
        exp_req       = 1'b0;
        exp_we        = 1'b0;
        exp_addr      = '0;
        exp_wdata     = '0;
        exp_chk_rdata = 1'b1;
        exp_chk_wdata = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = {$urandom(), $urandom()};
    endtask

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, exp_ready});
            if (exp_chk_rdata) chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, exp_rdata});
            chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
            chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
            if (exp_chk_wdata) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, exp_wdata});
            chk("hit_count", {16'd0, hit_count}, STATS ? sat(exp_hits) : 0);
            chk("miss_count", {16'd0, miss_count}, STATS ? sat(exp_miss) : 0);
            if (cpu_ready) begin
                last_rdata     = cpu_rdata;
                last_ready_cyc = cyc;
            end
            if (mem_req) last_mem_addr = mem_addr;
        end
    end

    task automatic do_read(input logic [15:0] a, input int lat);
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = a;
        cpu_wdata = 16'($urandom());
        idle_exp();
        if (m_hit(a)) begin
            exp_ready = 1'b1;
            exp_rdata = mem_m[a];
            step();
            exp_hits++;
        end else begin
            step();
            exp_miss++;
            for (int k = 1; k <= lat; k++) begin
                exp_req       = 1'b1;
                exp_addr      = {a[15:2], 2'b00};
                exp_chk_wdata = 1'b0;
                if (k == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = line_of(a);
                end
                step();
            end
            m_valid[a[3:2]] = 1'b1;
            m_tag[a[3:2]]   = a[15:4];
            idle_exp();
            exp_ready = 1'b1;
            exp_rdata = mem_m[a];
            step();
        end
        cpu_read = 1'b0;
        idle_exp();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int lat);
        cpu_write = 1'b1;
        cpu_read  = 1'($urandom_range(0, 1));
        cpu_addr  = a;
        cpu_wdata = d;
        idle_exp();
        step();
        for (int k = 1; k <= lat; k++) begin
            exp_req       = 1'b1;
            exp_we        = 1'b1;
            exp_addr      = a;
            exp_wdata     = d;
            exp_ready     = (k == lat);
            exp_chk_rdata = (k != lat);
            if (k == lat) mem_ack = 1'b1;
            step();
        end
        mem_m[a]  = d;
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
        idle_exp();
    endtask

    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_read  = 1'b0;
            cpu_write = 1'b0;
            cpu_addr  = 16'($urandom());
            idle_exp();
            mem_ack   = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    initial begin
        logic [15:0] a;
        int          op;
        reset_n   = 1'b0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        exp_hits  = 0;
        exp_miss  = 0;
        idle_exp();
        for (int i = 0; i < 65536; i++) mem_m[i] = 16'(i * 40503) ^ 16'h5A5A;
        mem_m[16'h0010] = 16'hA000;
        mem_m[16'h0011] = 16'hA001;
        mem_m[16'h0012] = 16'hA002;
        mem_m[16'h0013] = 16'hA003;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;

        step();
        step();
        step();
        reset_n = 1'b1;
        step();

        // Directed plan with hand-computed expectations.
        req_cyc = cyc + 1;
        do_read(16'h0013, 2);
        chk("plan_rd13_data", {16'd0, last_rdata}, 32'h0000A003);
        chk("plan_rd13_fill_addr", {16'd0, last_mem_addr}, 32'h00000010);
        chk("plan_rd13_cycles", last_ready_cyc - req_cyc + 1, 4);
        chk("plan_rd13_misses", {16'd0, miss_count}, STATS ? 1 : 0);

        req_cyc = cyc + 1;
        do_read(16'h0011, 2);
        chk("plan_rd11_data", {16'd0, last_rdata}, 32'h0000A001);
        chk("plan_rd11_cycles", last_ready_cyc - req_cyc + 1, 1);
        chk("plan_rd11_hits", {16'd0, hit_count}, STATS ? 1 : 0);

        do_write(16'h0012, 16'h5555, 2);
        chk("plan_wr12_addr", {16'd0, last_mem_addr}, 32'h00000012);
        do_read(16'h0012, 2);
        chk("plan_rd12_data", {16'd0, last_rdata}, 32'h00005555);

        do_write(16'h0102, 16'h1234, 3);
        do_read(16'h0102, 2);
        chk("plan_rd102_data", {16'd0, last_rdata}, 32'h00001234);
        chk("plan_rd102_fill_addr", {16'd0, last_mem_addr}, 32'h00000100);

        do_read(16'h0010, 2);
        do_read(16'h0110, 1);
        do_read(16'h0010, 3);
        chk("plan_conflict_data", {16'd0, last_rdata}, 32'h0000A000);
        chk("plan_conflict_misses", {16'd0, miss_count}, STATS ? 5 : 0);
        chk("plan_conflict_hits", {16'd0, hit_count}, STATS ? 2 : 0);

        // Reset two cycles into a fill, then a late ack.
        cpu_read = 1'b1;
        cpu_addr = 16'h0024;
        idle_exp();
        step();
        exp_miss++;
        exp_req       = 1'b1;
        exp_addr      = 16'h0024;
        exp_chk_wdata = 1'b0;
        step();
        #2;
        reset_n  = 1'b0;
        cpu_read = 1'b0;
        idle_exp();
        exp_hits = 0;
        exp_miss = 0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        #1;
        chk("rst_req_async", {31'd0, mem_req}, 0);
        chk("rst_we_async", {31'd0, mem_we}, 0);
        step();
        reset_n   = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = line_of(16'h0024);
        step();
        do_read(16'h0024, 2);
        chk("rst_refill_addr", {16'd0, last_mem_addr}, 32'h00000024);
        chk("rst_refill_misses", {16'd0, miss_count}, STATS ? 1 : 0);

        // Randomized traffic over a few tags so hits, misses and conflicts all occur.
        for (int n = 0; n < 300; n++) begin
            a  = 16'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
            op = $urandom_range(0, 9);
            if (op < 6) do_read(a, $urandom_range(1, 4));
            else if (op < 9) do_write(a, 16'($urandom()), $urandom_range(1, 4));
            else do_idle($urandom_range(1, 3));
        end
        do_idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
